// File: rtl/sha256d_sequencer.sv
// sha256d_sequencer
//
// Command sequencer for the windowed SHA-256 compression core. One START
// runs the complete double-SHA256 of an 80-byte block header with no outside
// help. The sequencer steps through a fixed 9-entry command list, performs the
// RDY handshake with the core for each command, steers the H-bank and
// message-window selects for the surrounding memories, and captures the final
// 256-bit digest.
//
// Ports
//   clk     in   1    clock; all state changes on the rising edge
//   rst_n   in   1    asynchronous active-low reset
//   start   in   1    start request, only looked at while idle
//   busy    out  1    high from an accepted start until done/err
//   done    out  1    one-cycle pulse; digest holds the new result
//   err     out  1    one-cycle pulse when the core misses the rdy timeout
//   cmd     out  8    command to the core
//   rdy     in   1    core ready/complete flag
//   res     in   256  core digest output
//   h_sel   out  2    H-bank base (0: H[0..7], 1: H[8..15])
//   h_we    out  1    H-bank write enable
//   m_sel   out  2    message window (0: M[0..15], 1: M[16..31], 2: M[32..47])
//   m_we    out  1    message write enable
//   step    out  4    current step index 0..8
//   digest  out  256  last captured digest
module sha256d_sequencer #(
   parameter logic [7:0]  CMD_IDLE_V   = 8'd0,
   parameter logic [7:0]  CMD_LOAD_H_V = 8'd1,
   parameter logic [7:0]  CMD_HASH_V   = 8'd2,
   parameter logic [7:0]  CMD_SUM_H_V  = 8'd3,
   parameter logic [7:0]  CMD_SUM_M_V  = 8'd4,
   parameter logic [7:0]  CMD_DIGEST_V = 8'd5,
   parameter logic [15:0] TIMEOUT      = 16'd200
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   output logic         busy,
   output logic         done,
   output logic         err,
   output logic [7:0]   cmd,
   input  logic         rdy,
   input  logic [255:0] res,
   output logic [1:0]   h_sel,
   output logic         h_we,
   output logic [1:0]   m_sel,
   output logic         m_we,
   output logic [3:0]   step,
   output logic [255:0] digest
);

   localparam logic [3:0] LAST_STEP = 4'd8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RELEASE,
      S_FIN,
      S_ERR
   } state_t;

   state_t         state;
   state_t         state_nxt;
   logic [3:0]     step_q;
   logic [3:0]     step_nxt;
   logic [15:0]    tmo_q;
   logic [15:0]    tmo_nxt;
   logic [15:0]    tmo_inc;
   logic [255:0]   digest_q;
   logic [255:0]   digest_nxt;

   // Registered state: FSM state, step index, rdy timeout counter and the
   // captured digest. A reset mid-run simply drops everything back to idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         step_q   <= 4'd0;
         tmo_q    <= 16'd0;
         digest_q <= 256'd0;
      end else begin
         state    <= state_nxt;
         step_q   <= step_nxt;
         tmo_q    <= tmo_nxt;
         digest_q <= digest_nxt;
      end
   end

   // The timeout counter saturates so a stalled core can never wrap it back
   // below the limit.
   assign tmo_inc = (tmo_q == 16'hFFFF) ? tmo_q : tmo_q + 16'd1;

   // Next-state logic. rdy is only honoured in WAIT, so a core that still has
   // rdy high while a new command is being issued cannot complete it early.
   // RELEASE lasts until the core drops rdy, so every command is framed by
   // at least one idle cycle.
   always_comb begin
      state_nxt  = state;
      step_nxt   = step_q;
      tmo_nxt    = tmo_q;
      digest_nxt = digest_q;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt = S_ISSUE;
               step_nxt  = 4'd0;
            end
         end
         S_ISSUE: begin
            tmo_nxt   = 16'd0;
            state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (rdy) begin
               state_nxt = S_RELEASE;
               if (step_q == LAST_STEP) begin
                  digest_nxt = res;
               end
            end else begin
               tmo_nxt = tmo_inc;
               if (tmo_inc >= TIMEOUT) begin
                  state_nxt = S_ERR;
                  step_nxt  = 4'd0;
               end
            end
         end
         S_RELEASE: begin
            if (!rdy) begin
               if (step_q == LAST_STEP) begin
                  state_nxt = S_FIN;
                  step_nxt  = 4'd0;
               end else begin
                  state_nxt = S_ISSUE;
                  step_nxt  = step_q + 4'd1;
               end
            end
         end
         S_FIN: begin
            state_nxt = S_IDLE;
         end
         S_ERR: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
            step_nxt  = 4'd0;
         end
      endcase
   end

   // Output decode. The command, selects and write enables of a step are only
   // presented while that command is in flight (ISSUE and WAIT); everywhere
   // else the core sees the idle command and the memories see zero selects.
   always_comb begin
      cmd   = CMD_IDLE_V;
      h_sel = 2'd0;
      m_sel = 2'd0;
      h_we  = 1'b0;
      m_we  = 1'b0;
      if (state == S_ISSUE || state == S_WAIT) begin
         case (step_q)
            4'd0: cmd = CMD_LOAD_H_V;
            4'd1: cmd = CMD_HASH_V;
            4'd2: begin
               cmd   = CMD_SUM_H_V;
               h_sel = 2'd1;
               h_we  = 1'b1;
            end
            4'd3: begin
               cmd   = CMD_LOAD_H_V;
               h_sel = 2'd1;
            end
            4'd4: begin
               cmd   = CMD_HASH_V;
               m_sel = 2'd1;
            end
            4'd5: begin
               cmd   = CMD_SUM_M_V;
               h_sel = 2'd1;
               m_sel = 2'd2;
               m_we  = 1'b1;
            end
            4'd6: cmd = CMD_LOAD_H_V;
            4'd7: begin
               cmd   = CMD_HASH_V;
               m_sel = 2'd2;
            end
            4'd8: cmd = CMD_DIGEST_V;
            default: cmd = CMD_IDLE_V;
         endcase
      end
   end

   assign busy   = (state == S_ISSUE) || (state == S_WAIT) || (state == S_RELEASE);
   assign done   = (state == S_FIN);
   assign err    = (state == S_ERR);
   assign step   = step_q;
   assign digest = digest_q;

endmodule

// File: tb/tb_sha256d_sequencer.sv
// tb_sha256d_sequencer
//
// Bench for sha256d_sequencer. Each run is planned ahead as a per-cycle
// timeline: the core's latency and rdy hold time per step are chosen (fixed
// or random), and the expected outputs for every cycle are computed from the
// step table with plain cycle arithmetic. The timeline is then played into
// the DUT and every output is compared on every cycle.
module tb_sha256d_sequencer;

   localparam int MAXC        = 512;
   localparam int TIMEOUT_CYC = 200;
   localparam logic [255:0] GENESIS =
      256'h6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000;

   // Step table: command, H-bank select, message window, write enables.
   localparam logic [7:0] STEP_CMD  [9] = '{8'd1, 8'd2, 8'd3, 8'd1, 8'd2, 8'd4, 8'd1, 8'd2, 8'd5};
   localparam logic [1:0] STEP_HSEL [9] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0};
   localparam logic [1:0] STEP_MSEL [9] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd0, 2'd2, 2'd0};

   logic         clk;
   logic         rst_n;
   logic         start;
   logic         busy;
   logic         done;
   logic         err;
   logic [7:0]   cmd;
   logic         rdy;
   logic [255:0] res;
   logic [1:0]   h_sel;
   logic         h_we;
   logic [1:0]   m_sel;
   logic         m_we;
   logic [3:0]   step;
   logic [255:0] digest;

   sha256d_sequencer dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .busy   (busy),
      .done   (done),
      .err    (err),
      .cmd    (cmd),
      .rdy    (rdy),
      .res    (res),
      .h_sel  (h_sel),
      .h_we   (h_we),
      .m_sel  (m_sel),
      .m_we   (m_we),
      .step   (step),
      .digest (digest)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Planned timeline for the current run.
   logic [7:0]   e_cmd  [MAXC];
   logic [1:0]   e_hsel [MAXC];
   logic [1:0]   e_msel [MAXC];
   logic         e_hwe  [MAXC];
   logic         e_mwe  [MAXC];
   logic         e_busy [MAXC];
   logic         e_done [MAXC];
   logic         e_err  [MAXC];
   logic [3:0]   e_step [MAXC];
   logic [255:0] e_dig  [MAXC];
   logic         d_start[MAXC];
   logic         d_rdy  [MAXC];
   logic [255:0] d_res  [MAXC];
   int           run_len;
   logic [255:0] model_digest;

   int           tests;
   int           fails;
   int           done_count;
   int           done_cyc;
   int           err_count;
   int           err_cyc;
   logic [7:0]   prev_cmd;
   logic [7:0]   seq[$];
   logic [7:0]   lit_seq[9];

   function automatic logic [255:0] rand256();
      return {$urandom(), $urandom(), $urandom(), $urandom(),
              $urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic chk(input string name, input int cyc, input logic [255:0] act, input logic [255:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // Step i drives its command from cycle a through cycle b inclusive.
   task automatic fill_cmd(input int i, input int a, input int b);
      for (int c = a; c <= b; c++) begin
         e_cmd[c]  = STEP_CMD[i];
         e_hsel[c] = STEP_HSEL[i];
         e_msel[c] = STEP_MSEL[i];
         e_hwe[c]  = (i == 2);
         e_mwe[c]  = (i == 5);
         e_busy[c] = 1'b1;
         e_step[c] = 4'(i);
      end
   endtask

   // Cycle 0 is the idle cycle in which start is high; the first command
   // appears in cycle 1. A command seen in cycle t with rdy rising in cycle
   // t+lat (lat >= 1) stays visible through t+lat, then idles until the
   // first cycle rdy is low (at least one cycle), and the next command starts
   // right after.
   task automatic build_run(input bit fixed, input int tmo_step, input int hold3,
                            input logic [255:0] final_res, input bit rand_start);
      int t;
      int lat;
      int hold;
      int rel_end;
      int acc;
      acc = MAXC;
      for (int c = 0; c < MAXC; c++) begin
         e_cmd[c]   = 8'd0;
         e_hsel[c]  = 2'd0;
         e_msel[c]  = 2'd0;
         e_hwe[c]   = 1'b0;
         e_mwe[c]   = 1'b0;
         e_busy[c]  = 1'b0;
         e_done[c]  = 1'b0;
         e_err[c]   = 1'b0;
         e_step[c]  = 4'd0;
         e_dig[c]   = model_digest;
         d_start[c] = 1'b0;
         d_rdy[c]   = 1'b0;
         d_res[c]   = rand256();
      end
      d_start[0] = 1'b1;
      t = 1;
      for (int i = 0; i < 9; i++) begin
         if (i == tmo_step) begin
            fill_cmd(i, t, t + TIMEOUT_CYC);
            e_err[t + TIMEOUT_CYC + 1] = 1'b1;
            if (rand_start) begin
               for (int c = 1; c <= t + TIMEOUT_CYC; c++) d_start[c] = ($urandom_range(2, 0) == 0);
            end
            run_len = t + TIMEOUT_CYC + 4;
            return;
         end
         lat  = fixed ? 3 : int'($urandom_range(6, 1));
         hold = fixed ? 1 : int'($urandom_range(4, 1));
         if (i == 3 && hold3 > 0) hold = hold3;
         if (!fixed && lat >= 2 && $urandom_range(3, 0) == 0) d_rdy[t] = 1'b1;
         fill_cmd(i, t, t + lat);
         for (int c = t + lat; c < t + lat + hold; c++) d_rdy[c] = 1'b1;
         rel_end = t + lat + ((hold > 1) ? hold : 1);
         for (int c = t + lat + 1; c <= rel_end; c++) begin
            e_busy[c] = 1'b1;
            e_step[c] = 4'(i);
         end
         if (i == 8) begin
            acc        = t + lat;
            d_res[acc] = final_res;
         end
         t = rel_end + 1;
      end
      e_done[t] = 1'b1;
      for (int c = acc + 1; c < MAXC; c++) e_dig[c] = final_res;
      model_digest = final_res;
      if (rand_start) begin
         for (int c = 1; c < t; c++) d_start[c] = ($urandom_range(2, 0) == 0);
         d_start[t] = 1'b1;
      end
      run_len = t + 4;
   endtask

   task automatic apply_stimulus(input int c);
      start = d_start[c];
      rdy   = d_rdy[c];
      res   = d_res[c];
   endtask

   task automatic check_output(input int c);
      chk("cmd",    c, 256'(cmd),    256'(e_cmd[c]));
      chk("h_sel",  c, 256'(h_sel),  256'(e_hsel[c]));
      chk("m_sel",  c, 256'(m_sel),  256'(e_msel[c]));
      chk("h_we",   c, 256'(h_we),   256'(e_hwe[c]));
      chk("m_we",   c, 256'(m_we),   256'(e_mwe[c]));
      chk("busy",   c, 256'(busy),   256'(e_busy[c]));
      chk("done",   c, 256'(done),   256'(e_done[c]));
      chk("err",    c, 256'(err),    256'(e_err[c]));
      chk("step",   c, 256'(step),   256'(e_step[c]));
      chk("digest", c, digest,       e_dig[c]);
      if (done === 1'b1) begin
         done_count++;
         done_cyc = c;
      end
      if (err === 1'b1) begin
         err_count++;
         err_cyc = c;
      end
      if (cmd !== 8'd0 && prev_cmd === 8'd0) seq.push_back(cmd);
      prev_cmd = cmd;
   endtask

   // Plays cycles 0..upto-1 of the planned timeline; entered and left just
   // after a rising edge.
   task automatic run_timeline(input int upto);
      done_count = 0;
      done_cyc   = -1;
      err_count  = 0;
      err_cyc    = -1;
      prev_cmd   = 8'd0;
      seq.delete();
      for (int c = 0; c < upto; c++) begin
         apply_stimulus(c);
         @(negedge clk);
         check_output(c);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_cmd"},    0, 256'(cmd),   256'd0);
      chk({tag, "_busy"},   0, 256'(busy),  256'd0);
      chk({tag, "_done"},   0, 256'(done),  256'd0);
      chk({tag, "_err"},    0, 256'(err),   256'd0);
      chk({tag, "_h_sel"},  0, 256'(h_sel), 256'd0);
      chk({tag, "_m_sel"},  0, 256'(m_sel), 256'd0);
      chk({tag, "_h_we"},   0, 256'(h_we),  256'd0);
      chk({tag, "_m_we"},   0, 256'(m_we),  256'd0);
      chk({tag, "_step"},   0, 256'(step),  256'd0);
      chk({tag, "_digest"}, 0, digest,      256'd0);
   endtask

   initial begin
      int stop;
      tests        = 0;
      fails        = 0;
      model_digest = 256'd0;
      lit_seq      = '{8'd1, 8'd2, 8'd3, 8'd1, 8'd2, 8'd4, 8'd1, 8'd2, 8'd5};
      start        = 1'b0;
      rdy          = 1'b0;
      res          = 256'd0;
      rst_n        = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      check_reset_values("reset");
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Fixed 3-cycle core with the genesis header digest.
      $display("[TB] run A: fixed latency, genesis digest");
      build_run(1'b1, -1, 0, GENESIS, 1'b0);
      run_timeline(run_len);
      chk("runA_done_count", 0, 256'(done_count), 256'd1);
      chk("runA_done_cycle", 0, 256'(done_cyc),   256'd46);
      chk("runA_digest",     0, digest,           GENESIS);
      chk("runA_seq_len",    0, 256'(seq.size()), 256'd9);
      for (int i = 0; i < 9; i++) begin
         if (i < seq.size()) chk("runA_seq", i, 256'(seq[i]), 256'(lit_seq[i]));
      end

      // rdy held high for six cycles after step 3 completes, start pulses.
      $display("[TB] run B: long rdy hold on step 3");
      build_run(1'b0, -1, 6, rand256(), 1'b1);
      run_timeline(run_len);
      chk("runB_done_count", 0, 256'(done_count), 256'd1);

      // Core never answers step 1.
      $display("[TB] run C: timeout in step 1");
      build_run(1'b1, 1, 0, 256'd0, 1'b1);
      run_timeline(run_len);
      chk("runC_err_count",  0, 256'(err_count),  256'd1);
      chk("runC_err_cycle",  0, 256'(err_cyc),    256'd207);
      chk("runC_done_count", 0, 256'(done_count), 256'd0);

      for (int r = 0; r < 6; r++) begin
         $display("[TB] random run %0d", r);
         build_run(1'b0, -1, 0, rand256(), 1'b1);
         run_timeline(run_len);
         chk("rand_done_count", r, 256'(done_count), 256'd1);
      end

      // Reset while step 4 is waiting on the core.
      $display("[TB] reset during step 4");
      build_run(1'b0, -1, 0, rand256(), 1'b0);
      stop = 0;
      for (int c = MAXC - 1; c >= 0; c--) begin
         if (e_step[c] == 4'd4 && e_cmd[c] != 8'd0) stop = c + 1;
      end
      run_timeline(stop);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_values("async_reset");
      start = 1'b0;
      rdy   = 1'b0;
      @(posedge clk);
      #1;
      check_reset_values("held_reset");
      rst_n        = 1'b1;
      model_digest = 256'd0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("post_reset_cmd",  c, 256'(cmd),  256'd0);
         chk("post_reset_done", c, 256'(done), 256'd0);
         chk("post_reset_busy", c, 256'(busy), 256'd0);
      end
      @(posedge clk);
      #1;

      $display("[TB] run after reset");
      build_run(1'b0, -1, 0, rand256(), 1'b1);
      run_timeline(run_len);
      chk("final_done_count", 0, 256'(done_count), 256'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
